// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: job, operand, MAC and result signals of the MAC sequencer.
// master is the sequencer side, slave is the environment (job source, MAC, result sink).
interface mac_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int LEN_W  = 8
);
   logic              start;
   logic [LEN_W-1:0]  cfg_len;
   logic              busy;
   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              mac_rst;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic              MAC_START;
   logic [ACC_W-1:0]  MAC_ACC;
   logic              mac_done;
   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  res_data;
   logic              res_err;
   modport master (
      input  start, cfg_len, op_valid, op_a, op_b, MAC_ACC, mac_done, res_ready,
      output busy, op_ready, mac_rst, A, B, MAC_START, res_valid, res_data, res_err
   );
   modport slave (
      output start, cfg_len, op_valid, op_a, op_b, MAC_ACC, mac_done, res_ready,
      input  busy, op_ready, mac_rst, A, B, MAC_START, res_valid, res_data, res_err
   );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: clears the MAC, issues one MAC_START/mac_done exchange per operand pair
// and returns the final accumulator (or a timeout error) on the result port.
module mac_sequencer #(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 40,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 64
) (
   input logic                clk,
   input logic                reset,
   mac_sequencer_if.master    bus
);
   localparam int TMR_W = $clog2(TIMEOUT);
   typedef enum logic [2:0] {IDLE, CLEAR, WAIT_OP, RUN, GAP, RESULT} state_e;
   state_e            state_q, state_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [ACC_W-1:0]  acc_q, acc_d, res_data_q, res_data_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic              res_err_q, res_err_d;
   logic              busy_q, op_ready_q, mac_rst_q, mac_start_q, res_valid_q;
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      tmr_d      = tmr_q;
      acc_d      = acc_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      a_d        = a_q;
      b_d        = b_q;
      case (state_q)
         IDLE: if (bus.start) begin
            rem_d   = bus.cfg_len;
            state_d = CLEAR;
         end
         CLEAR: begin
            acc_d      = '0;
            res_data_d = '0;
            res_err_d  = 1'b0;
            state_d    = rem_q == '0 ? RESULT : WAIT_OP;
         end
         WAIT_OP: if (bus.op_valid) begin
            a_d     = bus.op_a;
            b_d     = bus.op_b;
            tmr_d   = '0;
            state_d = RUN;
         end
         // mac_done is checked first so a completion on the last allowed cycle is not an error
         RUN: if (bus.mac_done) begin
            acc_d   = bus.MAC_ACC;
            rem_d   = rem_q - 1'b1;
            state_d = GAP;
         end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            res_err_d  = 1'b1;
            res_data_d = acc_q;
            state_d    = RESULT;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
         GAP: begin
            res_data_d = rem_q == '0 ? acc_q : res_data_q;
            state_d    = rem_q == '0 ? RESULT : WAIT_OP;
         end
         RESULT: if (bus.res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // handshake outputs are registered from the next state so they line up with state_q
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         tmr_q       <= '0;
         acc_q       <= '0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         busy_q      <= 1'b0;
         op_ready_q  <= 1'b0;
         mac_rst_q   <= 1'b0;
         mac_start_q <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         tmr_q       <= tmr_d;
         acc_q       <= acc_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         a_q         <= a_d;
         b_q         <= b_d;
         busy_q      <= state_d != IDLE;
         op_ready_q  <= state_d == WAIT_OP;
         mac_rst_q   <= state_d == CLEAR;
         mac_start_q <= state_d == RUN;
         res_valid_q <= state_d == RESULT;
      end
   end
   assign bus.busy      = busy_q;
   assign bus.op_ready  = op_ready_q;
   assign bus.mac_rst   = mac_rst_q;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.MAC_START = mac_start_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_err   = res_err_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: scoreboard bench with a behavioural MAC answering MAC_START/mac_done.
module tb_mac_sequencer;
   typedef struct {logic [39:0] data; logic err;} exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   exp_t sb[$];
   int n_vec = 0, n_bad = 0;
   int mac_lat = 1;
   bit mac_dead = 1'b0;
   logic [39:0] macc = '0;
   int cnt = 0;
   bit fired = 1'b0;
   int rst_pulses = 0, bursts = 0, hi = 0, last_hi = 0, gap = 0, last_gap = 0;
   bit ms_prev = 1'b0;
   mac_sequencer_if #(.DATA_W(16), .ACC_W(40), .LEN_W(8)) bus ();
   mac_sequencer #(.DATA_W(16), .ACC_W(40), .LEN_W(8), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;
   // MAC model: one accumulate per MAC_START burst, mac_done after mac_lat high cycles
   always @(negedge clk) begin
      if (bus.mac_rst) macc = '0;
      bus.mac_done = 1'b0;
      if (!bus.MAC_START) begin
         cnt = 0;
         fired = 1'b0;
      end else if (!fired) begin
         cnt++;
         if (cnt >= mac_lat && !mac_dead) begin
            macc = macc + 40'(bus.A) * 40'(bus.B);
            bus.MAC_ACC = macc;
            bus.mac_done = 1'b1;
            fired = 1'b1;
         end
      end
   end
   always @(negedge clk) begin
      if (bus.mac_rst) rst_pulses++;
      if (!bus.MAC_START && !bus.op_ready && bus.busy) gap++;
      if (bus.MAC_START && !ms_prev) begin
         bursts++;
         last_gap = gap;
         gap = 0;
      end
      if (bus.MAC_START) hi++;
      else if (ms_prev) begin
         last_hi = hi;
         hi = 0;
      end
      ms_prev = bus.MAC_START;
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic start_job(input logic [7:0] len);
      bus.start = 1'b1;
      bus.cfg_len = len;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
   endtask
   task automatic feed(input logic [15:0] a, input logic [15:0] b);
      int t = 0;
      bus.op_a = a;
      bus.op_b = b;
      bus.op_valid = 1'b1;
      while (!bus.op_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("op_ready_seen", 64'(bus.op_ready), 64'(1));
      @(posedge clk);
      #1 bus.op_valid = 1'b0;
      @(negedge clk);
      check("A_reg", 64'(bus.A), 64'(a));
      check("B_reg", 64'(bus.B), 64'(b));
   endtask
   task automatic get_result(input string tag);
      int t = 0;
      exp_t e;
      while (!bus.res_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_valid"}, 64'(bus.res_valid), 64'(1));
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 64'(sb.size()), 64'(1));
      end else begin
         e = sb.pop_front();
         check({tag, "_data"}, 64'(bus.res_data), 64'(e.data));
         check({tag, "_err"}, 64'(bus.res_err), 64'(e.err));
      end
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
      @(negedge clk);
      check({tag, "_idle"}, 64'(bus.busy), 64'(0));
   endtask
   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int r0, b0;
      logic [39:0] d0;
      bit stable;
      bus.start = 1'b0;
      bus.cfg_len = '0;
      bus.op_valid = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.res_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outputs", 64'({bus.busy, bus.op_ready, bus.mac_rst, bus.MAC_START,
                                bus.res_valid, bus.res_err}), 64'(0));
      check("rst_res_data", 64'(bus.res_data), 64'(0));
      reset = 1'b0;
      @(negedge clk);
      // single term
      r0 = rst_pulses;
      b0 = bursts;
      sb.push_back('{40'd15, 1'b0});
      start_job(8'd1);
      check("t1_busy", 64'(bus.busy), 64'(1));
      feed(16'h0003, 16'h0005);
      get_result("t1");
      check("t1_mac_rst_pulses", 64'(rst_pulses - r0), 64'(1));
      check("t1_bursts", 64'(bursts - b0), 64'(1));
      // two terms, one-cycle re-arm gap between bursts
      b0 = bursts;
      sb.push_back('{40'd493883950, 1'b0});
      start_job(8'd2);
      feed(16'h8235, 16'h0002);
      feed(16'h56CE, 16'h56CE);
      get_result("t2");
      check("t2_bursts", 64'(bursts - b0), 64'(2));
      check("t2_gap", 64'(last_gap), 64'(1));
      // zero-length job
      r0 = rst_pulses;
      b0 = bursts;
      sb.push_back('{40'd0, 1'b0});
      start_job(8'd0);
      check("t3_clear", 64'({bus.mac_rst, bus.res_valid}), 64'(2));
      @(negedge clk);
      check("t3_valid_at_3", 64'(bus.res_valid), 64'(1));
      get_result("t3");
      check("t3_mac_rst_pulses", 64'(rst_pulses - r0), 64'(1));
      check("t3_no_burst", 64'(bursts - b0), 64'(0));
      // MAC never answers
      mac_dead = 1'b1;
      sb.push_back('{40'd0, 1'b1});
      start_job(8'd1);
      feed(16'h0009, 16'h0009);
      get_result("t4");
      check("t4_run_cycles", 64'(last_hi), 64'(64));
      check("t4_start_low", 64'(bus.MAC_START), 64'(0));
      mac_dead = 1'b0;
      // result held under back-pressure, start ignored while busy
      sb.push_back('{40'd14, 1'b0});
      start_job(8'd1);
      feed(16'h0002, 16'h0007);
      for (int t = 0; t < 300 && !bus.res_valid; t++) @(negedge clk);
      d0 = bus.res_data;
      stable = 1'b1;
      bus.cfg_len = 8'd5;
      for (int i = 0; i < 10; i++) begin
         bus.start = (i == 3);
         @(negedge clk);
         if (bus.res_data !== d0 || bus.res_valid !== 1'b1) stable = 1'b0;
      end
      bus.start = 1'b0;
      check("t5_hold_stable", 64'(stable), 64'(1));
      get_result("t5");
      @(negedge clk);
      check("t5_start_ignored", 64'(bus.busy), 64'(0));
      // reset in the middle of RUN
      mac_dead = 1'b1;
      start_job(8'd1);
      feed(16'h0004, 16'h0004);
      repeat (5) @(negedge clk);
      check("t6_in_run", 64'(bus.MAC_START), 64'(1));
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_outputs", 64'({bus.busy, bus.op_ready, bus.mac_rst, bus.MAC_START,
                                   bus.res_valid, bus.res_err}), 64'(0));
      check("t6_rst_ab", 64'({bus.A, bus.B}), 64'(0));
      reset = 1'b0;
      mac_dead = 1'b0;
      @(negedge clk);
      sb.push_back('{40'hFFFE0002, 1'b0});
      start_job(8'd2);
      feed(16'hFFFF, 16'hFFFF);
      feed(16'h0001, 16'h0001);
      get_result("t6");
      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
